sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Owns the SDRAM pins and shares them between the write engine (sdram_write), the read engine (sdram_read) and the periodic refresh requirement.
- Generates the refresh tick and grants exclusive bus ownership to one engine at a time via its en input, using round-robin with a hold limit.
- Muxes the owner's command/addr/bank/data/mask onto the SDRAM pins, and issues AUTO REFRESH itself when no engine owns the bus.
- Sits between the wb_sdram top level and the two engines.

Parameters:
- REFRESH_INTERVAL, 1560: clocks between refresh ticks (15.6 us at 100 MHz); legal range 16..65535.
- T_RFC, 10: clocks of NOP after an arbiter-issued AUTO REFRESH.
- GRANT_MAX, 512: clocks an owner may hold the bus while the other engine is requesting.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- wr_req  in  1  write FIFO not empty.
- rd_req  in  1  read request pending.
- wr_en  out  1  enable to write engine.
- rd_en  out  1  enable to read engine.
- wr_ready  in  1  write engine idle with no delay outstanding.
- rd_ready  in  1  read engine idle with no delay outstanding.
- wr_command  in  3  write engine command.
- wr_addr  in  12  write engine address.
- wr_bank  in  2  write engine bank.
- wr_data  in  16  write engine data.
- wr_mask  in  2  write engine data mask.
- rd_command  in  3  read engine command.
- rd_addr  in  12  read engine address.
- rd_bank  in  2  read engine bank.
- rd_mask  in  2  read engine data mask.
- auto_refresh  out  1  one-clock refresh tick, broadcast to both engines.
- sd_command  out  3  SDRAM command.
- sd_addr  out  12  SDRAM address.
- sd_bank  out  2  SDRAM bank.
- sd_data  out  16  SDRAM write data.
- sd_mask  out  2  SDRAM data mask.
- sd_data_oe  out  1  data bus drive enable.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst==0, asynchronous):
  - state=IDLE; wr_en=rd_en=0; auto_refresh=0.
  - refresh counter=REFRESH_INTERVAL-1; refresh_pending=0; last_grant=READ, so write wins the first tie.
  - hold counter=0; sd_command=SDRAM_CMD_NOP; sd_addr=0, sd_bank=0, sd_data=0, sd_mask=0, sd_data_oe=0.
- Reset mid-operation: all outputs return to reset values immediately; no further commands are issued.
- Refresh timer:
  - Free-running down-counter. At 0 it pulses auto_refresh for exactly one clock, reloads REFRESH_INTERVAL-1 and sets refresh_pending.
  - If an engine is granted (en high) on the tick cycle, that engine owns the refresh and refresh_pending clears the same cycle.
  - A tick during IDLE, REFRESH or RELEASE leaves refresh_pending set.
  - A tick while refresh_pending is already set keeps it set; no counting of missed refreshes.
- State machine (registered):
  - IDLE:
    - Priority 1: if refresh_pending, go to REFRESH and drive sd_command=SDRAM_CMD_AR for one clock.
    - Priority 2: else if both wr_req and rd_req, grant the engine not equal to last_grant.
    - Priority 3: else grant whichever engine requests.
    - Grant means entering WR_OWN or RD_OWN, asserting that engine's en the next clock, setting last_grant and clearing the hold counter.
  - REFRESH: NOP for T_RFC clocks, clear refresh_pending, go to IDLE. Requests are ignored during this state.
  - WR_OWN / RD_OWN:
    - en held high; hold counter increments while the other engine requests, saturating at GRANT_MAX.
    - Release when the owner's req drops, or when hold counter==GRANT_MAX and the other engine requests. Release means deassert en and go to RELEASE.
  - RELEASE: owner's mux selection retained; wait until the owner's ready==1, then go to IDLE. In IDLE the other requester is granted next by round-robin.
- Mux:
  - In WR_OWN, or in RELEASE with owner=write: sd_* = wr_*, and sd_data_oe=1.
  - In RD_OWN, or in RELEASE with owner=read: sd_* = rd_*, sd_data=0, sd_data_oe=0.
  - Otherwise the arbiter drives: NOP (AR only on the REFRESH entry clock), addr/bank/data/mask=0.
  - The mux is combinational from registered state/owner only, so no command crosses an ownership change.
- Latency: request in IDLE to en high is 1 clock; en low to IDLE is at least 1 clock, plus the engine's ready delay.
- Simultaneous events:
  - Refresh tick on the same clock a request arrives in IDLE: the request is granted; the tick is not owned and stays pending.
  - Owner req drop on the same clock hold reaches GRANT_MAX: single release.

Test Plan:
- Refresh only: REFRESH_INTERVAL=16, no requests, release reset → auto_refresh pulses at clocks 16, 32, …; sd_command=AR one clock after each tick, then T_RFC NOPs.
- Single writer: wr_req=1 in IDLE with no refresh pending → wr_en=1 next clock; sd_command follows wr_command with sd_data_oe=1. Drop wr_req with wr_ready=1 → state IDLE 2 clocks later.
- Tie: wr_req=rd_req=1 from reset → write granted first; after write release, read granted; rd_en=1 and sd_data_oe=0.
- Starvation: wr_req held high, rd_req=1, GRANT_MAX=8 → wr_en drops after 8 clocks; rd_en rises once wr_ready=1 and IDLE is reached.
- Refresh under ownership: tick while wr_en=1 → refresh_pending stays 0; no arbiter AR is issued on release.
- Async reset: rst=0 mid-WR_OWN, between clock edges → wr_en=0 and sd_command=NOP without waiting for a clock edge.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bus between the SDRAM arbiter and its two engines plus the SDRAM pins.
// The master modport is the arbiter's view; slave is the engine/pin side.
interface sdram_arbiter_if;
  logic        wr_req;
  logic        rd_req;
  logic        wr_en;
  logic        rd_en;
  logic        wr_ready;
  logic        rd_ready;
  logic [2:0]  wr_command;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic [2:0]  rd_command;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic [1:0]  rd_mask;
  logic        auto_refresh;
  logic [2:0]  sd_command;
  logic [11:0] sd_addr;
  logic [1:0]  sd_bank;
  logic [15:0] sd_data;
  logic [1:0]  sd_mask;
  logic        sd_data_oe;
  logic        busy;

  modport master (
    input  wr_req, rd_req, wr_ready, rd_ready,
    input  wr_command, wr_addr, wr_bank, wr_data, wr_mask,
    input  rd_command, rd_addr, rd_bank, rd_mask,
    output wr_en, rd_en, auto_refresh,
    output sd_command, sd_addr, sd_bank, sd_data, sd_mask, sd_data_oe, busy
  );

  modport slave (
    output wr_req, rd_req, wr_ready, rd_ready,
    output wr_command, wr_addr, wr_bank, wr_data, wr_mask,
    output rd_command, rd_addr, rd_bank, rd_mask,
    input  wr_en, rd_en, auto_refresh,
    input  sd_command, sd_addr, sd_bank, sd_data, sd_mask, sd_data_oe, busy
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM pins between the write and read engines, round-robin with a
// hold limit, and issues AUTO REFRESH itself when a refresh tick goes unowned.
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 1560,
  parameter int T_RFC            = 10,
  parameter int GRANT_MAX        = 512
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.master bus
);

  localparam logic [2:0] SDRAM_CMD_NOP = 3'b111;
  localparam logic [2:0] SDRAM_CMD_AR  = 3'b001;

  localparam int HOLD_W = (GRANT_MAX < 1) ? 1 : $clog2(GRANT_MAX + 1);
  localparam int RFC_W  = (T_RFC < 1) ? 1 : $clog2(T_RFC + 1);

  localparam logic [15:0]       REF_RELOAD = 16'(REFRESH_INTERVAL - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(GRANT_MAX);
  localparam logic [RFC_W-1:0]  RFC_LAST   = RFC_W'(T_RFC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REFRESH = 3'd1,
    WR_OWN  = 3'd2,
    RD_OWN  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  state_t            state;
  grant_t            last_grant;
  logic [15:0]       ref_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [RFC_W-1:0]  rfc_cnt;
  logic              refresh_pending;
  logic              wr_en_q;
  logic              rd_en_q;
  logic              auto_refresh_q;

  logic tick;
  logic wr_drop;
  logic rd_drop;
  logic keep_bus;

  assign tick    = (ref_cnt == 16'd0);
  assign wr_drop = !bus.wr_req || ((hold_cnt == HOLD_MAX) && bus.rd_req);
  assign rd_drop = !bus.rd_req || ((hold_cnt == HOLD_MAX) && bus.wr_req);
  // An engine owns a tick only if it holds the bus on both sides of the tick edge.
  assign keep_bus = ((state == WR_OWN) && !wr_drop) || ((state == RD_OWN) && !rd_drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      last_grant      <= GRANT_RD;
      ref_cnt         <= REF_RELOAD;
      hold_cnt        <= '0;
      rfc_cnt         <= '0;
      refresh_pending <= 1'b0;
      wr_en_q         <= 1'b0;
      rd_en_q         <= 1'b0;
      auto_refresh_q  <= 1'b0;
    end else begin
      auto_refresh_q <= tick;
      ref_cnt        <= tick ? REF_RELOAD : (ref_cnt - 16'd1);

      case (state)
        IDLE: begin
          if (refresh_pending) begin
            state   <= REFRESH;
            rfc_cnt <= '0;
          end else if (bus.wr_req && (!bus.rd_req || (last_grant == GRANT_RD))) begin
            state      <= WR_OWN;
            wr_en_q    <= 1'b1;
            last_grant <= GRANT_WR;
            hold_cnt   <= '0;
          end else if (bus.rd_req) begin
            state      <= RD_OWN;
            rd_en_q    <= 1'b1;
            last_grant <= GRANT_RD;
            hold_cnt   <= '0;
          end
        end

        REFRESH: begin
          if (rfc_cnt == RFC_LAST) begin
            state           <= IDLE;
            refresh_pending <= 1'b0;
          end else begin
            rfc_cnt <= rfc_cnt + RFC_W'(1);
          end
        end

        WR_OWN: begin
          if (wr_drop) begin
            wr_en_q <= 1'b0;
            state   <= RELEASE;
          end else if (bus.rd_req && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        RD_OWN: begin
          if (rd_drop) begin
            rd_en_q <= 1'b0;
            state   <= RELEASE;
          end else if (bus.wr_req && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        RELEASE: begin
          if ((last_grant == GRANT_WR) ? bus.wr_ready : bus.rd_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // A new tick overrides the end-of-refresh clear so it is never lost.
      if (tick) begin
        refresh_pending <= !keep_bus;
      end
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.auto_refresh = auto_refresh_q;
  assign bus.busy         = (state != IDLE);

  logic wr_sel;
  logic rd_sel;

  assign wr_sel = (state == WR_OWN) || ((state == RELEASE) && (last_grant == GRANT_WR));
  assign rd_sel = (state == RD_OWN) || ((state == RELEASE) && (last_grant == GRANT_RD));

  // Pin mux depends only on registered state, so a command never straddles a handover.
  always_comb begin
    bus.sd_command = SDRAM_CMD_NOP;
    bus.sd_addr    = 12'd0;
    bus.sd_bank    = 2'd0;
    bus.sd_data    = 16'd0;
    bus.sd_mask    = 2'd0;
    bus.sd_data_oe = 1'b0;
    if (wr_sel) begin
      bus.sd_command = bus.wr_command;
      bus.sd_addr    = bus.wr_addr;
      bus.sd_bank    = bus.wr_bank;
      bus.sd_data    = bus.wr_data;
      bus.sd_mask    = bus.wr_mask;
      bus.sd_data_oe = 1'b1;
    end else if (rd_sel) begin
      bus.sd_command = bus.rd_command;
      bus.sd_addr    = bus.rd_addr;
      bus.sd_bank    = bus.rd_bank;
      bus.sd_mask    = bus.rd_mask;
    end else if ((state == REFRESH) && (rfc_cnt == '0)) begin
      bus.sd_command = SDRAM_CMD_AR;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter: outputs compared every cycle against a
// reference model built from refresh timing, ownership and round-robin rules.
module tb_sdram_arbiter;

  localparam int RI = 16;
  localparam int TR = 4;
  localparam int GM = 8;
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_AR  = 3'b001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_arbiter_if bus();

  sdram_arbiter #(
    .REFRESH_INTERVAL(RI),
    .T_RFC(TR),
    .GRANT_MAX(GM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=write 2=read; rfc_left counts refresh clocks remaining.
  int m_edges;
  int m_owner;
  bit m_releasing;
  int m_rfc_left;
  bit m_pending;
  int m_last;
  int m_hold;
  bit m_tick;

  task automatic model_reset();
    m_edges     = 0;
    m_owner     = 0;
    m_releasing = 1'b0;
    m_rfc_left  = 0;
    m_pending   = 1'b0;
    m_last      = 2;
    m_hold      = 0;
    m_tick      = 1'b0;
  endtask

  task automatic model_step();
    bit wq, rq, own_req, oth_req, owned_through, tick_now, own_ready;
    wq = bus.wr_req;
    rq = bus.rd_req;
    m_edges++;
    tick_now  = ((m_edges % RI) == 0);
    own_req   = (m_owner == 1) ? wq : rq;
    oth_req   = (m_owner == 1) ? rq : wq;
    own_ready = (m_owner == 1) ? bus.wr_ready : bus.rd_ready;
    owned_through = (m_owner != 0) && !m_releasing && own_req && !((m_hold == GM) && oth_req);

    if (m_rfc_left > 0) begin
      m_rfc_left--;
      if (m_rfc_left == 0) m_pending = 1'b0;
    end else if (m_owner != 0 && m_releasing) begin
      if (own_ready) begin
        m_owner     = 0;
        m_releasing = 1'b0;
      end
    end else if (m_owner != 0) begin
      if (!owned_through) m_releasing = 1'b1;
      else if (oth_req && m_hold < GM) m_hold++;
    end else if (m_pending) begin
      m_rfc_left = TR + 1;
    end else if (wq || rq) begin
      if (wq && rq) m_owner = 3 - m_last;
      else          m_owner = wq ? 1 : 2;
      m_last = m_owner;
      m_hold = 0;
    end

    m_tick = tick_now;
    if (tick_now) m_pending = !owned_through;
  endtask

  task automatic check_outputs();
    bit wsel, rsel;
    logic [31:0] e_cmd, e_addr, e_bank, e_data, e_mask;
    wsel = (m_owner == 1);
    rsel = (m_owner == 2);
    if (wsel) begin
      e_cmd = 32'(bus.wr_command); e_addr = 32'(bus.wr_addr); e_bank = 32'(bus.wr_bank);
      e_data = 32'(bus.wr_data);   e_mask = 32'(bus.wr_mask);
    end else if (rsel) begin
      e_cmd = 32'(bus.rd_command); e_addr = 32'(bus.rd_addr); e_bank = 32'(bus.rd_bank);
      e_data = 32'd0;              e_mask = 32'(bus.rd_mask);
    end else begin
      e_cmd = (m_rfc_left == TR + 1) ? 32'(CMD_AR) : 32'(CMD_NOP);
      e_addr = 32'd0; e_bank = 32'd0; e_data = 32'd0; e_mask = 32'd0;
    end
    check("wr_en", 32'(bus.wr_en), 32'(wsel && !m_releasing));
    check("rd_en", 32'(bus.rd_en), 32'(rsel && !m_releasing));
    check("auto_refresh", 32'(bus.auto_refresh), 32'(m_tick));
    check("busy", 32'(bus.busy), 32'((m_owner != 0) || (m_rfc_left > 0)));
    check("sd_command", 32'(bus.sd_command), e_cmd);
    check("sd_addr", 32'(bus.sd_addr), e_addr);
    check("sd_bank", 32'(bus.sd_bank), e_bank);
    check("sd_data", 32'(bus.sd_data), e_data);
    check("sd_mask", 32'(bus.sd_mask), e_mask);
    check("sd_data_oe", 32'(bus.sd_data_oe), 32'(wsel));
  endtask

  // Phases: idle (refresh only), both requesting (tie + hold limit), then random.
  task automatic drive_inputs(input int cyc);
    if (cyc < 40) begin
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
    end else if (cyc < 160) begin
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
    end else begin
      if ($urandom_range(0, 5) == 0) bus.wr_req = !bus.wr_req;
      if ($urandom_range(0, 5) == 0) bus.rd_req = !bus.rd_req;
    end
    bus.wr_ready   = (cyc < 160) ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus.rd_ready   = (cyc < 160) ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus.wr_command = 3'($urandom);
    bus.wr_addr    = 12'($urandom);
    bus.wr_bank    = 2'($urandom);
    bus.wr_data    = 16'($urandom);
    bus.wr_mask    = 2'($urandom);
    bus.rd_command = 3'($urandom);
    bus.rd_addr    = 12'($urandom);
    bus.rd_bank    = 2'($urandom);
    bus.rd_mask    = 2'($urandom);
  endtask

  bit did_async_rst = 1'b0;

  initial begin
    rst = 1'b0;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.wr_ready = 1'b1; bus.rd_ready = 1'b1;
    bus.wr_command = 3'd0; bus.wr_addr = 12'd0; bus.wr_bank = 2'd0;
    bus.wr_data = 16'd0; bus.wr_mask = 2'd0;
    bus.rd_command = 3'd0; bus.rd_addr = 12'd0; bus.rd_bank = 2'd0; bus.rd_mask = 2'd0;
    repeat (2) @(negedge clk);
    model_reset();
    check_outputs();
    rst = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_inputs(cyc);
      model_step();
      @(negedge clk);
      check_outputs();
      if (!did_async_rst && cyc >= 1500 && m_owner == 1 && !m_releasing) begin
        #3 rst = 1'b0;
        #1;
        check("async_wr_en", 32'(bus.wr_en), 32'd0);
        check("async_sd_command", 32'(bus.sd_command), 32'(CMD_NOP));
        check("async_sd_data_oe", 32'(bus.sd_data_oe), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        model_reset();
        check_outputs();
        rst = 1'b1;
        did_async_rst = 1'b1;
      end
    end

    check("async_rst_reached", 32'(did_async_rst), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
